// File: rtl/cart_pkg.sv
// Shared types, bankswitch codes and mask helper for the cartridge loader.
package cart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DRAIN,
      FINALIZE,
      DONE
   } cart_state_t;

   // Bankswitch codes as reported by detect2600 on det_force_bs.
   typedef enum logic [3:0] {
      BS_NONE = 4'h0,
      BS_E0   = 4'h1,
      BS_3F   = 4'h2,
      BS_FE   = 4'h3,
      BS_AR   = 4'h4,
      BS_F0   = 4'h5,
      BS_E7   = 4'h6,
      BS_UA   = 4'h7,
      BS_CV   = 4'h8,
      BS_FA   = 4'h9,
      BS_DPC  = 4'hA,
      BS_3E   = 4'hB
   } bs_code_t;

   localparam logic [10:0] MIN_MASK = 11'h7FF;

   // Smallest (2^k)-1 covering the last byte address, never below MIN_MASK.
   function automatic logic [31:0] size_to_mask(input logic [31:0] size);
      logic [31:0] last;
      logic [31:0] mask;
      last = (size == 32'd0) ? 32'd0 : size - 32'd1;
      mask = 32'(MIN_MASK);
      for (int i = 0; i < 21; i++) begin
         if (mask < last) mask = {mask[30:0], 1'b1};
      end
      return mask;
   endfunction

endpackage

// File: rtl/cart_byte_fifo.sv
// Small power-of-two FIFO holding {addr, data} write entries for cart memory.
module cart_byte_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 25,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_sys,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/cart_loader.sv
// Consumes the ioctl ROM stream, writes it to cart memory and latches the image summary.
// Optional CART_CHECKSUM_EN adds a 16-bit sum of all bytes written to memory.
module cart_loader
   import cart_pkg::*;
#(
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  CART_INDEX = 8'h00
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic              ioctl_wait,
   input  logic [3:0]        det_force_bs,
   input  logic              det_sc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [31:0]       cart_size,
   output logic [ADDR_W-1:0] cart_mask,
   output logic [3:0]        bs,
   output logic              sc,
   output logic              loaded,
`ifdef CART_CHECKSUM_EN
   output logic [15:0]       checksum,
`endif
   output logic              overflow
);

   localparam int unsigned       CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned       ENT_W    = ADDR_W + 8;
   localparam logic [31:0]       CAP_MASK = 32'((64'd1 << ADDR_W) - 64'd1);
   localparam logic [CNT_W-1:0]  WAIT_SET = CNT_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0]  WAIT_CLR = CNT_W'(FIFO_DEPTH - 3);

   cart_state_t      state;
   logic             dl_q;
   logic             active;
   logic             start;
   logic             sess_wr;
   logic             in_range;
   logic             push;
   logic             drop;
   logic             pop;
   logic             fifo_empty;
   logic             fifo_full;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] count_next;
   logic [ENT_W-1:0] head;
   logic [31:0]      mask_full;

   assign active     = ioctl_download & (ioctl_index == CART_INDEX);
   assign start      = active & ~dl_q & ((state == IDLE) | (state == DONE));
   assign sess_wr    = ioctl_wr & active & ((state == LOAD) | start);
   assign in_range   = (ioctl_addr >> ADDR_W) == 25'd0;
   assign push       = sess_wr & in_range & ~fifo_full;
   assign drop       = sess_wr & (~in_range | fifo_full);
   assign mem_valid  = ~fifo_empty;
   assign pop        = mem_valid & mem_ready;
   assign mem_addr   = head[ENT_W-1:8];
   assign mem_data   = head[7:0];
   assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
   assign mask_full  = size_to_mask(cart_size);

   // Reset doubles as flush so no write survives an abandoned load.
   cart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk_sys (clk_sys),
      .flush   (reset),
      .push    (push),
      .wr_data ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
      .pop     (pop),
      .rd_data (head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         dl_q       <= ioctl_download;
         ioctl_wait <= 1'b0;
         cart_size  <= '0;
         cart_mask  <= '0;
         bs         <= BS_NONE;
         sc         <= 1'b0;
         loaded     <= 1'b0;
         overflow   <= 1'b0;
`ifdef CART_CHECKSUM_EN
         checksum   <= '0;
`endif
      end else begin
         dl_q <= ioctl_download;

         // Hysteresis leaves room for one write already in flight when wait rises.
         if (count_next >= WAIT_SET) ioctl_wait <= 1'b1;
         else if (count_next <= WAIT_CLR) ioctl_wait <= 1'b0;

         case (state)
            IDLE:     if (start) state <= LOAD;
            LOAD:     if (!ioctl_download) state <= DRAIN;
            DRAIN:    if (fifo_empty) state <= FINALIZE;
            FINALIZE: begin
               bs        <= det_force_bs;
               sc        <= det_sc;
               cart_mask <= (mask_full > CAP_MASK) ? '1 : ADDR_W'(mask_full);
               loaded    <= 1'b1;
               state     <= DONE;
            end
            DONE:     if (start) state <= LOAD;
            default:  state <= IDLE;
         endcase

         if (start) begin
            cart_size <= '0;
            overflow  <= 1'b0;
            loaded    <= 1'b0;
         end
         if (sess_wr) cart_size <= {7'b0, ioctl_addr} + 32'd1;
         if (drop) overflow <= 1'b1;

`ifdef CART_CHECKSUM_EN
         if (start) checksum <= '0;
         else if (pop) checksum <= checksum + 16'(mem_data);
`endif
      end
   end

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: table of image loads plus stall, reset and index sequences.
module tb_cart_loader;

   logic        clk_sys;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_index;
   logic        ioctl_wait;
   logic [3:0]  det_force_bs;
   logic        det_sc;
   logic [16:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] cart_size;
   logic [16:0] cart_mask;
   logic [3:0]  bs;
   logic        sc;
   logic        loaded;
   logic        overflow;
`ifdef CART_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   cart_loader dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_index    (ioctl_index),
      .ioctl_wait     (ioctl_wait),
      .det_force_bs   (det_force_bs),
      .det_sc         (det_sc),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .cart_size      (cart_size),
      .cart_mask      (cart_mask),
      .bs             (bs),
      .sc             (sc),
      .loaded         (loaded),
`ifdef CART_CHECKSUM_EN
      .checksum       (checksum),
`endif
      .overflow       (overflow)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   function automatic logic [7:0] pat(input int unsigned a);
      return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
   endfunction

   // Memory-side monitor: address order, data pattern, stall stability.
   int unsigned mon_cnt   = 0;
   int unsigned mon_err   = 0;
   int unsigned stab_err  = 0;
   int unsigned stall_cyc = 0;
   int unsigned wait_cyc  = 0;
   int unsigned mon_base  = 0;
   logic        prev_stall = 1'b0;
   logic [16:0] prev_addr  = '0;
   logic [7:0]  prev_data  = '0;

   always @(posedge clk_sys) begin
      if (mem_valid && mem_ready) begin
         if (32'(mem_addr) != mon_cnt - mon_base || mem_data != pat(mon_cnt - mon_base))
            mon_err <= mon_err + 1;
         mon_cnt <= mon_cnt + 1;
      end
      if (prev_stall && (!mem_valid || mem_addr != prev_addr || mem_data != prev_data))
         stab_err <= stab_err + 1;
      if (mem_valid && !mem_ready) stall_cyc <= stall_cyc + 1;
      if (ioctl_wait) wait_cyc <= wait_cyc + 1;
      prev_stall <= mem_valid && !mem_ready && !reset;
      prev_addr  <= mem_addr;
      prev_data  <= mem_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic host_byte(input logic [24:0] a, input logic [7:0] d);
      int unsigned guard;
      guard = 0;
      while (ioctl_wait && guard < 200) begin
         @(negedge clk_sys);
         guard++;
      end
      if (guard >= 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL host_wait: ioctl_wait held %0d cycles, expected release", guard);
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
   endtask

   // Full download window; lat counts cycles from download fall until loaded.
   task automatic run_load(input logic [7:0] idx, input int unsigned nbytes, input bit oob,
                           input logic [3:0] dbs, input logic dsc,
                           output int unsigned lat, output logic ld_rise);
      @(negedge clk_sys);
      det_force_bs   = dbs;
      det_sc         = dsc;
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      ld_rise = loaded;
      for (int unsigned i = 0; i < nbytes; i++) host_byte(25'(i), pat(i));
      if (oob) host_byte(25'h20000, 8'hEE);
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      lat = 0;
      while (!loaded && lat < 20) begin
         @(negedge clk_sys);
         lat++;
      end
   endtask

   typedef struct {
      int unsigned nbytes;
      bit          oob;
      logic [3:0]  dbs;
      logic        dsc;
      logic [31:0] size;
      logic [31:0] mask;
      int unsigned writes;
      logic        ovf;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int unsigned lat;
      logic        ld_rise;
      int unsigned err0, stab0, stall0, wait0, cnt0;

      vecs[0] = '{4096, 1'b0, 4'h2, 1'b0, 32'h1000,  32'h0FFF,  4096, 1'b0};
      vecs[1] = '{2049, 1'b0, 4'h1, 1'b1, 32'h0801,  32'h0FFF,  2049, 1'b0};
      vecs[2] = '{1000, 1'b0, 4'h7, 1'b0, 32'h03E8,  32'h07FF,  1000, 1'b0};
      vecs[3] = '{0,    1'b0, 4'h3, 1'b1, 32'h0000,  32'h07FF,  0,    1'b0};
      vecs[4] = '{8,    1'b1, 4'hB, 1'b0, 32'h20001, 32'h1FFFF, 8,    1'b1};
      vecs[5] = '{2048, 1'b0, 4'h5, 1'b1, 32'h0800,  32'h07FF,  2048, 1'b0};
      vecs[6] = '{5000, 1'b0, 4'h9, 1'b0, 32'h1388,  32'h1FFF,  5000, 1'b0};

      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      ioctl_index    = 8'h00;
      det_force_bs   = 4'h0;
      det_sc         = 1'b0;
      mem_ready      = 1'b1;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);

      check("rst_loaded", 32'(loaded), 32'd0);
      check("rst_valid", 32'(mem_valid), 32'd0);
      check("rst_wait", 32'(ioctl_wait), 32'd0);
      check("rst_size", cart_size, 32'd0);
      check("rst_mask", 32'(cart_mask), 32'd0);
      check("rst_bs", 32'(bs), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      // Foreign download slot must leave the loader untouched.
      cnt0 = mon_cnt;
      run_load(8'h01, 10, 1'b0, 4'h6, 1'b1, lat, ld_rise);
      repeat (5) @(negedge clk_sys);
      check("idx_writes", mon_cnt - cnt0, 32'd0);
      check("idx_loaded", 32'(loaded), 32'd0);
      check("idx_size", cart_size, 32'd0);
      check("idx_bs", 32'(bs), 32'd0);

      for (int i = 0; i < 7; i++) begin
         mon_base = mon_cnt;
         err0     = mon_err;
         run_load(8'h00, vecs[i].nbytes, vecs[i].oob, vecs[i].dbs, vecs[i].dsc, lat, ld_rise);
         if (i > 0) check($sformatf("r%0d_loaded_drop", i), 32'(ld_rise), 32'd0);
         check($sformatf("r%0d_latency_3to4", i), 32'(lat >= 3 && lat <= 4), 32'd1);
         check($sformatf("r%0d_loaded", i), 32'(loaded), 32'd1);
         check($sformatf("r%0d_size", i), cart_size, vecs[i].size);
         check($sformatf("r%0d_mask", i), 32'(cart_mask), vecs[i].mask);
         check($sformatf("r%0d_bs", i), 32'(bs), 32'(vecs[i].dbs));
         check($sformatf("r%0d_sc", i), 32'(sc), 32'(vecs[i].dsc));
         check($sformatf("r%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
         check($sformatf("r%0d_writes", i), mon_cnt - mon_base, vecs[i].writes);
         check($sformatf("r%0d_order_errs", i), mon_err - err0, 32'd0);
      end

      // Memory stalls for 20 cycles during a burst.
      mon_base = mon_cnt;
      err0     = mon_err;
      stab0    = stab_err;
      stall0   = stall_cyc;
      wait0    = wait_cyc;
      mem_ready = 1'b0;
      fork
         begin
            repeat (20) @(negedge clk_sys);
            mem_ready = 1'b1;
         end
      join_none
      run_load(8'h00, 64, 1'b0, 4'hA, 1'b1, lat, ld_rise);
      check("stall_wait_rose", 32'(wait_cyc != wait0), 32'd1);
      check("stall_seen", 32'(stall_cyc != stall0), 32'd1);
      check("stall_data_stable", stab_err - stab0, 32'd0);
      check("stall_writes", mon_cnt - mon_base, 32'd64);
      check("stall_order_errs", mon_err - err0, 32'd0);
      check("stall_ovf", 32'(overflow), 32'd0);
      check("stall_loaded", 32'(loaded), 32'd1);
      check("stall_size", cart_size, 32'h40);
      check("stall_bs", 32'(bs), 32'hA);

      // Reset while LOAD holds pending writes.
      cnt0 = mon_cnt;
      mon_base = mon_cnt;
      mem_ready = 1'b0;
      @(negedge clk_sys);
      det_force_bs   = 4'hC;
      ioctl_index    = 8'h00;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      host_byte(25'd0, pat(0));
      host_byte(25'd1, pat(1));
      host_byte(25'd2, pat(2));
      check("rml_pre_valid", 32'(mem_valid), 32'd1);
      reset = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      check("rml_valid", 32'(mem_valid), 32'd0);
      check("rml_loaded", 32'(loaded), 32'd0);
      check("rml_bs", 32'(bs), 32'd0);
      check("rml_size", cart_size, 32'd0);
      ioctl_download = 1'b0;
      mem_ready      = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("rml_no_write", mon_cnt - cnt0, 32'd0);

      mon_base = mon_cnt;
      err0     = mon_err;
      run_load(8'h00, 100, 1'b0, 4'h4, 1'b0, lat, ld_rise);
      check("fresh_latency_3to4", 32'(lat >= 3 && lat <= 4), 32'd1);
      check("fresh_loaded", 32'(loaded), 32'd1);
      check("fresh_size", cart_size, 32'd100);
      check("fresh_mask", 32'(cart_mask), 32'h7FF);
      check("fresh_bs", 32'(bs), 32'h4);
      check("fresh_writes", mon_cnt - mon_base, 32'd100);
      check("fresh_order_errs", mon_err - err0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
